// File: rtl/vend_pkg.sv
// Shared definitions for the card payment terminal: FSM state encoding
// and the interface widths agreed with the vending machine.
package vend_pkg;

  // Cost width must match the vending machine's COST bus.
  localparam int COST_W = 3;

  // Default card balance width.
  localparam int BAL_W_DEF = 8;

  // Payment-side transaction states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_AUTH  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/auth_delay_counter.sv
// Authorisation latency counter: after a start on the cost-capture edge,
// done is high during the cycle ending in edge AUTH_LATENCY after that edge.
// It stays high until cleared so the decision cannot be missed.
module auth_delay_counter #(
  parameter int AUTH_LATENCY = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  input  logic clear,
  output logic done
);

  localparam logic [2:0] TARGET = 3'(AUTH_LATENCY);

  logic [2:0] cnt_q, cnt_d;
  logic       run_q, run_d;

  // Next count: start loads one edge already elapsed, clear stops the count.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clear) begin
      run_d = 1'b0;
      cnt_d = 3'd0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = 3'd1;
    end else if (run_q && (cnt_q != TARGET)) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_q <= 3'd0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done = run_q && (cnt_q == TARGET);

endmodule

// File: rtl/card_payment_terminal.sv
// Payment-side responder for the vending machine transaction interface.
// Loads the card balance on insertion, authorises or declines a selection
// after a fixed latency, debits on VEND and strobes a write-back on removal.
module card_payment_terminal #(
  parameter int AUTH_LATENCY = 2,
  parameter int BAL_W        = vend_pkg::BAL_W_DEF,
  parameter int COST_W       = vend_pkg::COST_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CARD_IN,
  input  logic [BAL_W-1:0]  CARD_BALANCE,
  input  logic [COST_W-1:0] COST,
  input  logic              INVALID_SEL,
  input  logic              VEND,
  input  logic              FAILED_TRAN,
  output logic              VALID_TRAN,
  output logic              DECLINED,
  output logic [BAL_W-1:0]  BALANCE,
  output logic              WB_STROBE,
  output logic              BUSY
);

  import vend_pkg::*;

  state_e              state_q, state_d;
  logic                card_in_q, card_in_d;
  logic [BAL_W-1:0]    balance_q, balance_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic                valid_tran_q, valid_tran_d;
  logic                declined_q, declined_d;
  logic                wb_strobe_q, wb_strobe_d;
  logic                wb_pending_q, wb_pending_d;
  logic                busy_q, busy_d;
  logic                cnt_start, cnt_clear, auth_done;
  logic                insert;

  auth_delay_counter #(
    .AUTH_LATENCY(AUTH_LATENCY)
  ) u_auth_delay_counter (
    .CLK   (CLK),
    .RESET (RESET),
    .start (cnt_start),
    .clear (cnt_clear),
    .done  (auth_done)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    insert       = CARD_IN && !card_in_q;
    card_in_d    = CARD_IN;
    state_d      = state_q;
    balance_d    = balance_q;
    cost_d       = cost_q;
    valid_tran_d = 1'b0;
    declined_d   = 1'b0;
    wb_strobe_d  = 1'b0;
    wb_pending_d = 1'b0;
    cnt_start    = 1'b0;
    cnt_clear    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_pending_q) begin
          wb_strobe_d = 1'b1;
        end else if (insert) begin
          balance_d = CARD_BALANCE;
          state_d   = ST_READY;
        end
      end
      ST_READY: begin
        if (!CARD_IN) begin
          state_d     = ST_IDLE;
          wb_strobe_d = 1'b1;
        end else if ((COST != '0) && !INVALID_SEL) begin
          cost_d    = COST;
          cnt_start = 1'b1;
          state_d   = ST_AUTH;
        end
      end
      ST_AUTH: begin
        if (!CARD_IN) begin
          cnt_clear   = 1'b1;
          state_d     = ST_IDLE;
          wb_strobe_d = 1'b1;
        end else if (auth_done) begin
          cnt_clear = 1'b1;
          if (balance_q >= BAL_W'(cost_q)) begin
            valid_tran_d = 1'b1;
            state_d      = ST_HOLD;
          end else begin
            declined_d = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end
      ST_HOLD: begin
        if (VEND) begin
          balance_d = balance_q - BAL_W'(cost_q);
          if (!CARD_IN) begin
            state_d      = ST_IDLE;
            wb_pending_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (FAILED_TRAN) begin
          state_d = ST_DONE;
        end else if (!CARD_IN) begin
          state_d     = ST_IDLE;
          wb_strobe_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!CARD_IN) begin
          state_d     = ST_IDLE;
          wb_strobe_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; the card sample resets high so a card
  // already present at reset release must be seen low before it counts.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      card_in_q    <= 1'b1;
      balance_q    <= '0;
      cost_q       <= '0;
      valid_tran_q <= 1'b0;
      declined_q   <= 1'b0;
      wb_strobe_q  <= 1'b0;
      wb_pending_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      card_in_q    <= card_in_d;
      balance_q    <= balance_d;
      cost_q       <= cost_d;
      valid_tran_q <= valid_tran_d;
      declined_q   <= declined_d;
      wb_strobe_q  <= wb_strobe_d;
      wb_pending_q <= wb_pending_d;
      busy_q       <= busy_d;
    end
  end

  assign VALID_TRAN = valid_tran_q;
  assign DECLINED   = declined_q;
  assign BALANCE    = balance_q;
  assign WB_STROBE  = wb_strobe_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_card_payment_terminal.sv
// Self-checking bench for card_payment_terminal: a table of directed
// cycle vectors followed by randomized traffic against a session model.
module tb_card_payment_terminal;

  localparam int LAT = 2;

  logic       CLK;
  logic       RESET;
  logic       CARD_IN;
  logic [7:0] CARD_BALANCE;
  logic [2:0] COST;
  logic       INVALID_SEL;
  logic       VEND;
  logic       FAILED_TRAN;
  logic       VALID_TRAN;
  logic       DECLINED;
  logic [7:0] BALANCE;
  logic       WB_STROBE;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;

  card_payment_terminal #(
    .AUTH_LATENCY(LAT),
    .BAL_W(8),
    .COST_W(3)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CARD_IN      (CARD_IN),
    .CARD_BALANCE (CARD_BALANCE),
    .COST         (COST),
    .INVALID_SEL  (INVALID_SEL),
    .VEND         (VEND),
    .FAILED_TRAN  (FAILED_TRAN),
    .VALID_TRAN   (VALID_TRAN),
    .DECLINED     (DECLINED),
    .BALANCE      (BALANCE),
    .WB_STROBE    (WB_STROBE),
    .BUSY         (BUSY)
  );

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n;
    logic       card;
    logic [7:0] bal;
    logic [2:0] cost;
    logic       inv;
    logic       vend;
    logic       fail;
    logic       e_valid;
    logic       e_decl;
    logic       e_wb;
    logic       e_busy;
    logic [7:0] e_bal;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic card, input logic [7:0] bal,
                     input logic [2:0] cost, input logic inv, input logic vend,
                     input logic fail, input logic ev, input logic ed,
                     input logic ew, input logic eb, input logic [7:0] ebal);
    vec_t v;
    v.rst_n = rst_n; v.card = card; v.bal = bal; v.cost = cost;
    v.inv = inv; v.vend = vend; v.fail = fail;
    v.e_valid = ev; v.e_decl = ed; v.e_wb = ew; v.e_busy = eb; v.e_bal = ebal;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic apply_stimulus(input logic rst_n, input logic card,
                                input logic [7:0] bal, input logic [2:0] cost,
                                input logic inv, input logic vend, input logic fail);
    RESET        = rst_n;
    CARD_IN      = card;
    CARD_BALANCE = bal;
    COST         = cost;
    INVALID_SEL  = inv;
    VEND         = vend;
    FAILED_TRAN  = fail;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string name, input int idx,
                              input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, idx, actual, expected);
    end
  endtask

  // Session-level reference model: tracks whether a card session is open,
  // how many edges remain until the decision, and what the session has done.
  bit  m_prev_card;
  bit  m_active;
  int  m_bal;
  int  m_cost;
  int  m_wait;
  bit  m_authorised;
  bit  m_finished;
  bit  m_wb_later;
  bit  m_valid, m_decl, m_wb;

  task automatic model_step(input bit rst_n, input bit card, input int bal,
                            input int cost, input bit inv, input bit vend,
                            input bit fail);
    bit inserted;
    m_valid = 0; m_decl = 0; m_wb = 0;
    if (!rst_n) begin
      m_prev_card = 1; m_active = 0; m_bal = 0; m_cost = 0; m_wait = 0;
      m_authorised = 0; m_finished = 0; m_wb_later = 0;
      return;
    end
    inserted    = card && !m_prev_card;
    m_prev_card = card;
    if (m_wb_later) begin
      m_wb = 1;
      m_wb_later = 0;
    end else if (!m_active) begin
      if (inserted) begin
        m_active = 1; m_bal = bal; m_wait = 0;
        m_authorised = 0; m_finished = 0;
      end
    end else if (m_wait > 0) begin
      if (!card) begin
        m_active = 0; m_wb = 1; m_wait = 0;
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          if (m_bal >= m_cost) begin m_valid = 1; m_authorised = 1; end
          else begin m_decl = 1; m_finished = 1; end
        end
      end
    end else if (m_authorised) begin
      if (vend) begin
        m_bal = m_bal - m_cost; m_authorised = 0; m_finished = 1;
        if (!card) begin m_active = 0; m_wb_later = 1; end
      end else if (fail) begin
        m_authorised = 0; m_finished = 1;
      end else if (!card) begin
        m_active = 0; m_wb = 1; m_authorised = 0;
      end
    end else if (m_finished) begin
      if (!card) begin m_active = 0; m_wb = 1; end
    end else begin
      if (!card) begin
        m_active = 0; m_wb = 1;
      end else if (cost != 0 && !inv) begin
        m_cost = cost; m_wait = LAT;
      end
    end
  endtask

  initial begin
    bit       r_card;
    bit       r_rst;
    bit [7:0] r_bal;
    bit [2:0] r_cost;
    bit       r_inv, r_vend, r_fail;

    // Sufficient funds: balance 10, cost 3, vend, removal.
    add(0,0, 0,0,0,0,0, 0,0,0,0, 0);
    add(1,0, 0,0,0,0,0, 0,0,0,0, 0);
    add(1,1,10,0,0,0,0, 0,0,0,1,10);
    add(1,1,10,3,0,0,0, 0,0,0,1,10);
    add(1,1,10,0,0,0,0, 0,0,0,1,10);
    add(1,1,10,0,0,0,0, 1,0,0,1,10);
    add(1,1,10,0,0,0,0, 0,0,0,1,10);
    add(1,1,10,0,0,1,0, 0,0,0,1, 7);
    add(1,0, 0,0,0,0,0, 0,0,1,0, 7);
    add(1,0, 0,0,0,0,0, 0,0,0,0, 7);
    // Insufficient funds: balance 2, cost 5, later cost ignored.
    add(1,1, 2,0,0,0,0, 0,0,0,1, 2);
    add(1,1, 2,5,0,0,0, 0,0,0,1, 2);
    add(1,1, 2,0,0,0,0, 0,0,0,1, 2);
    add(1,1, 2,0,0,0,0, 0,1,0,1, 2);
    add(1,1, 2,1,0,0,0, 0,0,0,1, 2);
    add(1,1, 2,1,0,0,0, 0,0,0,1, 2);
    add(1,0, 0,0,0,0,0, 0,0,1,0, 2);
    // Invalid selection held for ten cycles, then removal during AUTH.
    add(1,1, 9,0,0,0,0, 0,0,0,1, 9);
    for (int i = 0; i < 10; i++) add(1,1, 9,6,1,0,0, 0,0,0,1, 9);
    add(1,1, 9,6,0,0,0, 0,0,0,1, 9);
    add(1,0, 9,0,0,0,0, 0,0,1,0, 9);
    add(1,0, 9,0,0,0,0, 0,0,0,0, 9);
    // VEND and removal on the same edge: write-back carries debited balance.
    add(1,1,10,0,0,0,0, 0,0,0,1,10);
    add(1,1,10,3,0,0,0, 0,0,0,1,10);
    add(1,1,10,0,0,0,0, 0,0,0,1,10);
    add(1,1,10,0,0,0,0, 1,0,0,1,10);
    add(1,0,10,0,0,1,0, 0,0,0,0, 7);
    add(1,0,10,0,0,0,0, 0,0,1,0, 7);
    add(1,0,10,0,0,0,0, 0,0,0,0, 7);
    // Dispense failure: no debit.
    add(1,1,10,0,0,0,0, 0,0,0,1,10);
    add(1,1,10,4,0,0,0, 0,0,0,1,10);
    add(1,1,10,0,0,0,0, 0,0,0,1,10);
    add(1,1,10,0,0,0,0, 1,0,0,1,10);
    add(1,1,10,0,0,0,1, 0,0,0,1,10);
    add(1,0,10,0,0,0,0, 0,0,1,0,10);
    add(1,0,10,0,0,0,0, 0,0,0,0,10);
    // Reset mid-HOLD, card held through release, then reinserted.
    add(1,1,10,0,0,0,0, 0,0,0,1,10);
    add(1,1,10,3,0,0,0, 0,0,0,1,10);
    add(1,1,10,0,0,0,0, 0,0,0,1,10);
    add(1,1,10,0,0,0,0, 1,0,0,1,10);
    add(0,1,10,0,0,0,0, 0,0,0,0, 0);
    add(1,1,10,0,0,0,0, 0,0,0,0, 0);
    add(1,1,10,3,0,0,0, 0,0,0,0, 0);
    add(1,0,10,0,0,0,0, 0,0,0,0, 0);
    add(1,1, 5,0,0,0,0, 0,0,0,1, 5);
    add(1,0, 5,0,0,0,0, 0,0,1,0, 5);
    add(1,0, 5,0,0,0,0, 0,0,0,0, 5);

    $display("[TB] directed vectors: %0d", vecs.size());
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].card, vecs[i].bal, vecs[i].cost,
                     vecs[i].inv, vecs[i].vend, vecs[i].fail);
      check_output("dir_valid",   i, 8'(VALID_TRAN), 8'(vecs[i].e_valid));
      check_output("dir_declined",i, 8'(DECLINED),   8'(vecs[i].e_decl));
      check_output("dir_wb",      i, 8'(WB_STROBE),  8'(vecs[i].e_wb));
      check_output("dir_busy",    i, 8'(BUSY),       8'(vecs[i].e_busy));
      check_output("dir_balance", i, BALANCE,        vecs[i].e_bal);
    end

    // Randomized traffic compared cycle by cycle with the session model.
    $display("[TB] random phase");
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    model_step(0, 0, 0, 0, 0, 0, 0);
    r_card = 0;
    for (int n = 0; n < 4000; n++) begin
      r_rst  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 11) == 0) r_card = ~r_card;
      r_bal  = 8'($urandom_range(0, 255));
      r_cost = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      r_inv  = ($urandom_range(0, 4) == 0);
      r_vend = ($urandom_range(0, 6) == 0);
      r_fail = ($urandom_range(0, 9) == 0);
      apply_stimulus(r_rst, r_card, r_bal, r_cost, r_inv, r_vend, r_fail);
      model_step(r_rst, r_card, int'(r_bal), int'(r_cost), r_inv, r_vend, r_fail);
      check_output("rnd_valid",    n, 8'(VALID_TRAN), 8'(m_valid));
      check_output("rnd_declined", n, 8'(DECLINED),   8'(m_decl));
      check_output("rnd_wb",       n, 8'(WB_STROBE),  8'(m_wb));
      check_output("rnd_busy",     n, 8'(BUSY),       8'(m_active));
      check_output("rnd_balance",  n, BALANCE,        8'(m_bal));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
